// File: rtl/io_pad_bridge_bottom.sv
// Bottom-edge IO bridge: synchronises and debounces chip pad inputs toward the
// fabric, and gates fabric outputs onto pads until configuration has settled.
module io_pad_bridge_bottom #(
    parameter int NUM_IN      = 14,
    parameter int NUM_OUT     = 7,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               config_done,
    input  logic [NUM_IN-1:0]  pad_in,
    output logic [NUM_IN-1:0]  fabric_in,
    input  logic [NUM_OUT-1:0] fabric_out,
    output logic [NUM_OUT-1:0] pad_out,
    output logic               running
);

    localparam int CNT_W  = $clog2(FILTER_LEN + 1);
    localparam int HOLD_W = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   filt_q;
            logic                   filt_d;
            logic                   sync_bit;

            assign sync_bit = sync_q[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in[gi]};
                end
            end

            // The counter only advances over an unbroken run of mismatching cycles.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync_bit != filt_q) begin
                    if (cnt_q == CNT_LAST) begin
                        filt_d = sync_bit;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign fabric_in[gi] = filt_q;
        end
    endgenerate

    state_t              state_q;
    state_t              state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [NUM_OUT-1:0]  pad_out_q;
    logic [NUM_OUT-1:0]  pad_out_d;
    logic                running_q;
    logic                running_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CONFIG;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Losing config_done always wins, from any state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!config_done) begin
            state_d = ST_CONFIG;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_CONFIG;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
        pad_out_d = running_d ? fabric_out : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out_q <= '0;
            running_q <= 1'b0;
        end else begin
            pad_out_q <= pad_out_d;
            running_q <= running_d;
        end
    end

    assign pad_out = pad_out_q;
    assign running = running_q;

endmodule

// File: tb/tb_io_pad_bridge_bottom.sv
// Bench for io_pad_bridge_bottom: directed scenarios plus randomized glitchy
// pad traffic, checked every cycle against a window-based reference model.
module tb_io_pad_bridge_bottom;

    localparam int NI = 14;
    localparam int NO = 7;
    localparam int S  = 2;
    localparam int F  = 3;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          config_done = 1'b0;
    logic [NI-1:0] pad_in = '0;
    logic [NI-1:0] fabric_in;
    logic [NO-1:0] fabric_out = '0;
    logic [NO-1:0] pad_out;
    logic          running;

    int tests = 0;
    int fails = 0;

    io_pad_bridge_bottom #(
        .NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(S), .FILTER_LEN(F), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .config_done(config_done), .pad_in(pad_in),
        .fabric_in(fabric_in), .fabric_out(fabric_out), .pad_out(pad_out), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: hist[k] is pad_in sampled k edges ago. A filtered bit
    // flips once the F samples that have reached the sync stage all disagree
    // with it. running holds once config_done has been seen high on H+1
    // consecutive edges.
    logic [NI-1:0] hist [S+F];
    logic [NI-1:0] m_filt = '0;
    logic [NO-1:0] m_pad  = '0;
    logic          m_run  = 1'b0;
    int            run_len = 0;

    initial begin
        for (int k = 0; k < S + F; k++) hist[k] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < S + F; k++) hist[k] = '0;
                m_filt  = '0;
                m_pad   = '0;
                m_run   = 1'b0;
                run_len = 0;
            end else begin
                for (int k = S + F - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = pad_in;
                for (int i = 0; i < NI; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int k = S; k < S + F; k++)
                        if (hist[k][i] == m_filt[i]) all_diff = 1'b0;
                    if (all_diff) m_filt[i] = ~m_filt[i];
                end
                if (config_done) begin
                    if (run_len < 1000) run_len++;
                end else begin
                    run_len = 0;
                end
                m_run = (run_len >= H + 1);
                m_pad = m_run ? fabric_out : '0;
            end
            #1;
            check("fabric_in_vs_model", 32'(fabric_in), 32'(m_filt));
            check("pad_out_vs_model", 32'(pad_out), 32'(m_pad));
            check("running_vs_model", 32'(running), 32'(m_run));
        end
    end

    logic [NI-1:0] base;
    logic [NI-1:0] gmask;
    int            gcnt;

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_fabric_in", 32'(fabric_in), 32'h0);
        check("reset_pad_out", 32'(pad_out), 32'h0);
        check("reset_running", 32'(running), 32'h0);

        // Step latency: all-ones appears after edge 5
        pad_in = 14'h3FFF;
        rst_n  = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("step_edge%0d", e), 32'(fabric_in), (e < 5) ? 32'h0 : 32'h3FFF);
        end
        check("model_step_pin", 32'(m_filt), 32'h3FFF);

        // Short pulse on bit 3 is rejected, held level is accepted at edge 5
        pad_in = '0;
        repeat (8) tick();
        pad_in = 14'h0008;
        repeat (2) tick();
        pad_in = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("pulse2_bit3", 32'(fabric_in[3]), 32'h0);
        end
        pad_in = 14'h0008;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("held_bit3_edge%0d", e), 32'(fabric_in[3]), (e == 5) ? 32'h1 : 32'h0);
        end
        pad_in = '0;
        repeat (6) tick();

        // Config hold sequence
        fabric_out  = 7'h55;
        config_done = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("hold_running_e%0d", e), 32'(running), (e == 5) ? 32'h1 : 32'h0);
            check($sformatf("hold_pad_out_e%0d", e), 32'(pad_out), (e == 5) ? 32'h55 : 32'h0);
        end

        // Drop and re-raise config_done
        config_done = 1'b0;
        tick();
        check("drop_running", 32'(running), 32'h0);
        check("drop_pad_out", 32'(pad_out), 32'h0);
        config_done = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("rehold_running_e%0d", e), 32'(running), (e == 5) ? 32'h1 : 32'h0);
        end

        // Short config_done pulse never reaches RUN
        config_done = 1'b0;
        tick();
        config_done = 1'b1;
        repeat (3) tick();
        config_done = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("short_cfg_running", 32'(running), 32'h0);
            check("short_cfg_pad_out", 32'(pad_out), 32'h0);
        end

        // Asynchronous reset mid-RUN and mid-filter count
        config_done = 1'b1;
        pad_in = 14'h3FFF;
        repeat (8) tick();
        check("pre_reset_running", 32'(running), 32'h1);
        pad_in = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_fabric_in", 32'(fabric_in), 32'h0);
        check("async_rst_pad_out", 32'(pad_out), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("post_rst_fabric_in", 32'(fabric_in), 32'h0);
            check($sformatf("post_rst_running_e%0d", e), 32'(running), (e >= 5) ? 32'h1 : 32'h0);
        end

        // Randomized pad traffic with 1..2 cycle glitches
        base = '0;
        gmask = '0;
        gcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                int b;
                b = $urandom_range(0, NI - 1);
                base[b] = ~base[b];
            end
            if (gcnt == 0 && $urandom_range(0, 3) == 0) begin
                gmask = '0;
                gmask[$urandom_range(0, NI - 1)] = 1'b1;
                gcnt = $urandom_range(1, 2);
            end
            pad_in = (gcnt > 0) ? (base ^ gmask) : base;
            if (gcnt > 0) gcnt--;
            fabric_out = NO'($urandom);
            if ($urandom_range(0, 29) == 0) config_done = ~config_done;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
